bloom_sweep_ctrl: RTL and testbench

Scheduler for the blooming phase of the core. It takes the sorted reflector candidates (block index plus distance) and, for each candidate in turn, runs two walkers outward from that candidate through the block array. Each walker drives one block at a time into bloom mode and advances only after that block reports completion. It keeps a coverage mask so that blocks already bloomed by an earlier candidate are skipped. Sits between the sort stage and the block array in the core top, replacing the inline bloom/sel FSM.

---
 rtl/bloom_pkg.sv | 18 +
 rtl/bloom_side_walker.sv | 56 +++++
 rtl/bloom_sweep_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_bloom_sweep_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bloom_pkg.sv
// Shared encodings for the bloom sweep scheduler and its side walkers.
package bloom_pkg;

    localparam logic [1:0] MODE_OFF   = 2'b00;
    localparam logic [1:0] MODE_REF   = 2'b01;
    localparam logic [1:0] MODE_BLOOM = 2'b10;

    localparam int                   IDX_WIDTH   = 6;
    localparam logic [IDX_WIDTH-1:0] INVALID_IDX = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SELECT = 2'd1,
        ST_SWEEP  = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

endpackage

// File: rtl/bloom_side_walker.sv
// One bloom walker: owns a block pointer and an alive bit, and steps one block
// per accepted bloom_end in direction DIR (-1 or +1).
module bloom_side_walker
    import bloom_pkg::*;
#(
    parameter int BLOCK_NUM = 40,
    parameter int NUM_WIDTH = 6,
    parameter int DIR       = -1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [NUM_WIDTH-1:0] load_ptr,
    input  logic                 load_alive,
    input  logic                 kill,
    input  logic [BLOCK_NUM-1:0] contains_bloom,
    input  logic [BLOCK_NUM-1:0] bloom_end,
    input  logic [BLOCK_NUM-1:0] covered,
    output logic [NUM_WIDTH-1:0] ptr,
    output logic                 alive,
    output logic                 hit
);

    logic [NUM_WIDTH-1:0] nxt;
    logic                 in_range;
    logic                 step_ok;

    always_comb begin
        hit = alive && bloom_end[ptr];
        if (DIR < 0) begin
            nxt      = ptr - NUM_WIDTH'(1);
            in_range = (ptr != '0);
        end else begin
            nxt      = ptr + NUM_WIDTH'(1);
            in_range = ({1'b0, ptr} < (NUM_WIDTH+1)'(BLOCK_NUM - 1));
        end
        // a covered neighbour is the other walker's trail (or an earlier run's), so stop there
        step_ok = contains_bloom[ptr] && in_range && !covered[nxt];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr   <= '0;
            alive <= 1'b0;
        end else if (load) begin
            ptr   <= load_ptr;
            alive <= load_alive;
        end else if (kill) begin
            alive <= 1'b0;
        end else if (hit) begin
            if (step_ok) ptr   <= nxt;
            else         alive <= 1'b0;
        end
    end

endmodule

// File: rtl/bloom_sweep_ctrl.sv
// Bloom phase scheduler: walks each sorted reflector candidate outward in both
// directions, one block at a time, skipping blocks already covered this run.
//   state  | meaning
//   IDLE   | waiting for start
//   SELECT | pick next candidate, skip covered ones, end on invalid
//   SWEEP  | left/right walkers drive blocks into bloom mode
//   DONE   | one-cycle done pulse
module bloom_sweep_ctrl
    import bloom_pkg::*;
#(
    parameter int BLOCK_NUM  = 40,
    parameter int NUM_WIDTH  = 6,
    parameter int DIST_WIDTH = 14,
    parameter int REF_NUM    = 4,
    parameter int WDOG_WIDTH = 12,
    parameter int WDOG_LIMIT = 4000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [REF_NUM*NUM_WIDTH-1:0]  cand_addr,
    input  logic [REF_NUM*DIST_WIDTH-1:0] cand_dist,
    input  logic [BLOCK_NUM-1:0]          contains_bloom,
    input  logic [BLOCK_NUM-1:0]          bloom_end,
    output logic [BLOCK_NUM*2-1:0]        blk_mode,
    output logic [DIST_WIDTH-1:0]         distance,
    output logic [BLOCK_NUM-1:0]          covered,
    output logic                          busy,
    output logic                          done,
    output logic                          wdog_err
);

    localparam int IDX_W = $clog2(REF_NUM + 1);

    state_t state, state_nxt;

    logic [NUM_WIDTH-1:0]  cand_a [REF_NUM];
    logic [DIST_WIDTH-1:0] cand_d [REF_NUM];
    logic [IDX_W-1:0]      idx;
    logic [WDOG_WIDTH-1:0] wdog;

    logic [NUM_WIDTH-1:0]  cur_a;
    logic [DIST_WIDTH-1:0] cur_d;
    logic [NUM_WIDTH:0]    a_plus;
    logic                  sel_end, sel_skip, sel_go;
    logic                  wdog_hit, both_dead, kill;
    logic [BLOCK_NUM-1:0]  hit_vec;

    logic [NUM_WIDTH-1:0]  ptr_l, ptr_r;
    logic                  alive_l, alive_r, hit_l, hit_r;

    always_comb begin
        // idx == REF_NUM falls through to an all-ones index, which ends the run
        cur_a = '1;
        cur_d = '0;
        for (int i = 0; i < REF_NUM; i++) begin
            if (idx == IDX_W'(i)) begin
                cur_a = cand_a[i];
                cur_d = cand_d[i];
            end
        end
        a_plus    = {1'b0, cur_a} + (NUM_WIDTH+1)'(1);
        sel_end   = (&cur_a) || ({1'b0, cur_a} >= (NUM_WIDTH+1)'(BLOCK_NUM));
        sel_skip  = !sel_end && covered[cur_a];
        sel_go    = (state == ST_SELECT) && !sel_end && !sel_skip;
        wdog_hit  = (wdog == WDOG_WIDTH'(WDOG_LIMIT));
        both_dead = !alive_l && !alive_r;
        kill      = (state == ST_SWEEP) && wdog_hit;
        hit_vec   = '0;
        for (int i = 0; i < BLOCK_NUM; i++) begin
            hit_vec[i] = (hit_l && ptr_l == NUM_WIDTH'(i)) ||
                         (hit_r && ptr_r == NUM_WIDTH'(i));
        end
    end

    bloom_side_walker #(
        .BLOCK_NUM (BLOCK_NUM),
        .NUM_WIDTH (NUM_WIDTH),
        .DIR       (-1)
    ) u_walk_l (
        .clk            (clk),
        .rst            (rst),
        .load           (sel_go),
        .load_ptr       (cur_a),
        .load_alive     (1'b1),
        .kill           (kill),
        .contains_bloom (contains_bloom),
        .bloom_end      (bloom_end),
        .covered        (covered),
        .ptr            (ptr_l),
        .alive          (alive_l),
        .hit            (hit_l)
    );

    bloom_side_walker #(
        .BLOCK_NUM (BLOCK_NUM),
        .NUM_WIDTH (NUM_WIDTH),
        .DIR       (1)
    ) u_walk_r (
        .clk            (clk),
        .rst            (rst),
        .load           (sel_go),
        .load_ptr       (a_plus[NUM_WIDTH-1:0]),
        .load_alive     (a_plus < (NUM_WIDTH+1)'(BLOCK_NUM)),
        .kill           (kill),
        .contains_bloom (contains_bloom),
        .bloom_end      (bloom_end),
        .covered        (covered),
        .ptr            (ptr_r),
        .alive          (alive_r),
        .hit            (hit_r)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_SELECT;
            ST_SELECT: begin
                if (sel_end)      state_nxt = ST_DONE;
                else if (!sel_skip) state_nxt = ST_SWEEP;
            end
            ST_SWEEP:  if (both_dead) state_nxt = ST_SELECT;
            ST_DONE:   state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != ST_IDLE);
        done     = (state == ST_DONE);
        blk_mode = '0;
        if (state == ST_SWEEP) begin
            for (int i = 0; i < BLOCK_NUM; i++) begin
                if ((alive_l && ptr_l == NUM_WIDTH'(i)) || (alive_r && ptr_r == NUM_WIDTH'(i)))
                    blk_mode[2*i +: 2] = MODE_BLOOM;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < REF_NUM; i++) begin
                cand_a[i] <= '0;
                cand_d[i] <= '0;
            end
            idx      <= '0;
            wdog     <= '0;
            covered  <= '0;
            distance <= '0;
            wdog_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        for (int i = 0; i < REF_NUM; i++) begin
                            cand_a[i] <= cand_addr[i*NUM_WIDTH +: NUM_WIDTH];
                            cand_d[i] <= cand_dist[i*DIST_WIDTH +: DIST_WIDTH];
                        end
                        idx      <= '0;
                        covered  <= '0;
                        wdog_err <= 1'b0;
                    end
                end
                ST_SELECT: begin
                    if (sel_skip) idx <= idx + IDX_W'(1);
                    if (sel_go) begin
                        distance <= cur_d;
                        wdog     <= '0;
                    end
                end
                ST_SWEEP: begin
                    covered <= covered | hit_vec;
                    // saturate at the limit so the abort stays asserted until the walkers drain
                    if (hit_l || hit_r) wdog <= '0;
                    else if (!wdog_hit) wdog <= wdog + WDOG_WIDTH'(1);
                    if (wdog_hit)  wdog_err <= 1'b1;
                    if (both_dead) idx <= idx + IDX_W'(1);
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bloom_sweep_ctrl.sv
// Directed bench for bloom_sweep_ctrl; a behavioural block array answers each
// bloom request with bloom_end in the same cycle the mode is seen.
module tb_bloom_sweep_ctrl;

    logic        clk;
    logic        rst;
    logic        start;
    logic [23:0] cand_addr;
    logic [55:0] cand_dist;
    logic [39:0] contains_bloom;
    logic [39:0] bloom_end;
    logic [79:0] blk_mode;
    logic [13:0] distance;
    logic [39:0] covered;
    logic        busy;
    logic        done;
    logic        wdog_err;

    int n_vec = 0;
    int n_err = 0;
    logic en = 1'b1;
    int pass_cnt [40];
    int base [40];
    int done_cnt = 0;
    int done_base = 0;

    bloom_sweep_ctrl dut (
        .clk            (clk),
        .rst            (rst),
        .start          (start),
        .cand_addr      (cand_addr),
        .cand_dist      (cand_dist),
        .contains_bloom (contains_bloom),
        .bloom_end      (bloom_end),
        .blk_mode       (blk_mode),
        .distance       (distance),
        .covered        (covered),
        .busy           (busy),
        .done           (done),
        .wdog_err       (wdog_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 40; i++) pass_cnt[i] = 0;
        bloom_end = '0;
    end

    // block array model: one bloom pass per cycle a block is held in bloom mode
    always @(negedge clk) begin
        for (int i = 0; i < 40; i++) begin
            if (en && blk_mode[2*i +: 2] == 2'b10) begin
                bloom_end[i] = 1'b1;
                pass_cnt[i]  = pass_cnt[i] + 1;
            end else begin
                bloom_end[i] = 1'b0;
            end
        end
        if (done) done_cnt = done_cnt + 1;
    end

    function automatic logic [39:0] span(input int lo, input int hi);
        logic [39:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic int pass_bad(input logic [39:0] exp);
        int bad;
        bad = 0;
        for (int i = 0; i < 40; i++)
            if ((pass_cnt[i] - base[i]) != (exp[i] ? 1 : 0)) bad++;
        return bad;
    endfunction

    task automatic run(input logic [23:0] a, input logic [55:0] d, input int budget,
                       input int restart_at, output int dcyc);
        int cyc;
        @(negedge clk);
        for (int i = 0; i < 40; i++) base[i] = pass_cnt[i];
        done_base = done_cnt;
        cand_addr = a;
        cand_dist = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        dcyc = -1;
        while (cyc <= budget && dcyc < 0) begin
            if (done) dcyc = cyc;
            else begin
                if (cyc == restart_at) begin
                    start = 1'b1;
                    cand_addr = 24'hFFF003;
                end
                @(negedge clk);
                start = 1'b0;
                cyc++;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; cand_addr = '0; cand_dist = '0; contains_bloom = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy); end
        n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done); end
        n_vec++; if (blk_mode !== '0) begin n_err++; $display("FAIL reset_mode got %h want 0", blk_mode); end
        n_vec++; if (covered !== '0) begin n_err++; $display("FAIL reset_covered got %h want 0", covered); end
        n_vec++; if (distance !== '0) begin n_err++; $display("FAIL reset_distance got %0d want 0", distance); end
        n_vec++; if (wdog_err !== 1'b0) begin n_err++; $display("FAIL reset_wdog got %b want 0", wdog_err); end
    endtask

    task automatic test_isolated;
        int dcyc;
        contains_bloom = span(8, 12);
        run({6'h3F, 6'h3F, 6'h3F, 6'd10}, {14'd0, 14'd0, 14'd0, 14'd500}, 50, 0, dcyc);
        n_vec++; if (dcyc !== 8) begin n_err++; $display("FAIL iso_done_cycle got %0d want 8", dcyc); end
        n_vec++; if (covered !== span(7, 13)) begin n_err++; $display("FAIL iso_covered got %h want %h", covered, span(7, 13)); end
        n_vec++; if (pass_bad(span(7, 13)) !== 0) begin n_err++; $display("FAIL iso_passes got %0d bad blocks want 0", pass_bad(span(7, 13))); end
        n_vec++; if (distance !== 14'd500) begin n_err++; $display("FAIL iso_distance got %0d want 500", distance); end
        @(negedge clk);
        n_vec++; if (done_cnt - done_base !== 1) begin n_err++; $display("FAIL iso_done_pulses got %0d want 1", done_cnt - done_base); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL iso_busy_after got %b want 0", busy); end
    endtask

    task automatic test_last_block;
        int dcyc;
        contains_bloom = span(35, 39);
        run({6'h3F, 6'h3F, 6'h3F, 6'd39}, {14'd0, 14'd0, 14'd0, 14'd77}, 50, 0, dcyc);
        n_vec++; if (dcyc !== 10) begin n_err++; $display("FAIL last_done_cycle got %0d want 10", dcyc); end
        n_vec++; if (covered !== span(34, 39)) begin n_err++; $display("FAIL last_covered got %h want %h", covered, span(34, 39)); end
        n_vec++; if (pass_bad(span(34, 39)) !== 0) begin n_err++; $display("FAIL last_passes got %0d bad blocks want 0", pass_bad(span(34, 39))); end
    endtask

    task automatic test_first_block;
        int dcyc;
        contains_bloom = span(0, 2);
        run({6'h3F, 6'h3F, 6'h3F, 6'd0}, {14'd0, 14'd0, 14'd0, 14'd9}, 50, 0, dcyc);
        n_vec++; if (dcyc !== 7) begin n_err++; $display("FAIL first_done_cycle got %0d want 7", dcyc); end
        n_vec++; if (covered !== span(0, 3)) begin n_err++; $display("FAIL first_covered got %h want %h", covered, span(0, 3)); end
        n_vec++; if (pass_bad(span(0, 3)) !== 0) begin n_err++; $display("FAIL first_passes got %0d bad blocks want 0", pass_bad(span(0, 3))); end
    endtask

    task automatic test_overlap;
        int dcyc;
        contains_bloom = span(18, 24);
        run({6'h3F, 6'h3F, 6'd21, 6'd20}, {14'd0, 14'd0, 14'd300, 14'd200}, 50, 0, dcyc);
        n_vec++; if (dcyc !== 10) begin n_err++; $display("FAIL ovl_done_cycle got %0d want 10", dcyc); end
        n_vec++; if (covered !== span(17, 25)) begin n_err++; $display("FAIL ovl_covered got %h want %h", covered, span(17, 25)); end
        n_vec++; if (pass_bad(span(17, 25)) !== 0) begin n_err++; $display("FAIL ovl_passes got %0d bad blocks want 0", pass_bad(span(17, 25))); end
        n_vec++; if (distance !== 14'd200) begin n_err++; $display("FAIL ovl_distance got %0d want 200", distance); end
    endtask

    task automatic test_invalid_slot;
        int dcyc;
        contains_bloom = '0;
        run({6'd7, 6'd8, 6'h3F, 6'd15}, {14'd1, 14'd2, 14'd3, 14'd4}, 50, 0, dcyc);
        n_vec++; if (dcyc !== 5) begin n_err++; $display("FAIL inv_done_cycle got %0d want 5", dcyc); end
        n_vec++; if (covered !== span(15, 16)) begin n_err++; $display("FAIL inv_covered got %h want %h", covered, span(15, 16)); end
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL inv_busy_after got %b want 0", busy); end
    endtask

    task automatic test_busy_start;
        int dcyc;
        contains_bloom = '0;
        run({6'h3F, 6'h3F, 6'h3F, 6'd25}, {14'd0, 14'd0, 14'd0, 14'd40}, 50, 2, dcyc);
        n_vec++; if (dcyc !== 5) begin n_err++; $display("FAIL busy_done_cycle got %0d want 5", dcyc); end
        n_vec++; if (covered !== span(25, 26)) begin n_err++; $display("FAIL busy_covered got %h want %h", covered, span(25, 26)); end
        @(negedge clk);
        n_vec++; if (done_cnt - done_base !== 1) begin n_err++; $display("FAIL busy_done_pulses got %0d want 1", done_cnt - done_base); end
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL busy_idle_after got %b want 0", busy); end
    endtask

    task automatic test_watchdog;
        int cyc;
        int dcyc;
        contains_bloom = '0;
        en = 1'b0;
        @(negedge clk);
        cand_addr = {6'h3F, 6'h3F, 6'd30, 6'd5};
        cand_dist = {14'd0, 14'd0, 14'd222, 14'd111};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 1;
        while (!wdog_err && cyc < 5000) begin
            @(negedge clk);
            cyc++;
            if (cyc == 2) begin
                n_vec++; if (blk_mode[13:10] !== 4'b1010) begin n_err++; $display("FAIL wd_first_modes got %b want 1010", blk_mode[13:10]); end
            end
        end
        n_vec++; if (cyc !== 4003) begin n_err++; $display("FAIL wd_trip_cycle got %0d want 4003", cyc); end
        en = 1'b1;
        for (int i = 0; i < 40; i++) base[i] = pass_cnt[i];
        n_vec++; if (blk_mode !== '0) begin n_err++; $display("FAIL wd_walkers_stopped got %h want 0", blk_mode); end
        dcyc = -1;
        while (cyc < 4100 && dcyc < 0) begin
            if (done) dcyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_vec++; if (dcyc !== 4008) begin n_err++; $display("FAIL wd_done_cycle got %0d want 4008", dcyc); end
        n_vec++; if (covered !== span(30, 31)) begin n_err++; $display("FAIL wd_covered got %h want %h", covered, span(30, 31)); end
        n_vec++; if (pass_bad(span(30, 31)) !== 0) begin n_err++; $display("FAIL wd_next_passes got %0d bad blocks want 0", pass_bad(span(30, 31))); end
        n_vec++; if (distance !== 14'd222) begin n_err++; $display("FAIL wd_distance got %0d want 222", distance); end
        @(negedge clk);
        n_vec++; if (wdog_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky got %b want 1", wdog_err); end
        cand_addr = '1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (wdog_err !== 1'b0) begin n_err++; $display("FAIL wd_clear_on_start got %b want 0", wdog_err); end
        n_vec++; if (covered !== '0) begin n_err++; $display("FAIL wd_covered_clear got %h want 0", covered); end
        @(negedge clk);
        n_vec++; if (done !== 1'b1) begin n_err++; $display("FAIL wd_empty_run_done got %b want 1", done); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int cyc;
        int dcyc;
        contains_bloom = '1;
        @(negedge clk);
        cand_addr = {6'h3F, 6'h3F, 6'h3F, 6'd10};
        cand_dist = {14'd0, 14'd0, 14'd0, 14'd999};
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL rmid_busy got %b want 0", busy); end
        n_vec++; if (blk_mode !== '0) begin n_err++; $display("FAIL rmid_mode got %h want 0", blk_mode); end
        n_vec++; if (covered !== '0) begin n_err++; $display("FAIL rmid_covered got %h want 0", covered); end
        n_vec++; if (distance !== '0) begin n_err++; $display("FAIL rmid_distance got %0d want 0", distance); end
        rst = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++; if (busy !== 1'b1) begin n_err++; $display("FAIL rmid_restart got %b want 1", busy); end
        cyc = 1;
        dcyc = -1;
        while (cyc < 100 && dcyc < 0) begin
            if (done) dcyc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        n_vec++; if (dcyc !== 33) begin n_err++; $display("FAIL rmid_done_cycle got %0d want 33", dcyc); end
        n_vec++; if (covered !== {40{1'b1}}) begin n_err++; $display("FAIL rmid_covered_all got %h want ffffffffff", covered); end
        @(negedge clk);
    endtask

    initial begin
        test_reset;
        test_isolated;
        test_last_block;
        test_first_block;
        test_overlap;
        test_invalid_slot;
        test_busy_start;
        test_watchdog;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
